// File: rtl/odd_parity_serializer.sv
// odd_parity_serializer: accepts a byte over valid/ready and shifts out an
// asynchronous-serial frame on tx_out: start bit (0), 8 data bits LSB first,
// odd parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT clocks and the
// line idles high.
//
// Build option: define ODD_PARITY_SER_TWO_STOP_EN to emit two stop bits
// (frame = 12*CLKS_PER_BIT cycles instead of 11*CLKS_PER_BIT). Ports and
// parameters are identical in both builds.
module odd_parity_serializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx_out,
  output logic       busy
);

  // A one-clock bit period still needs a (constant zero) counter bit.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             parity_bit, parity_next;
  logic             tx_next;
`ifdef ODD_PARITY_SER_TWO_STOP_EN
  logic             stop2, stop2_next;
`endif

  logic bit_end;
  assign bit_end = (baud_cnt == CNT_MAX);

  // Handshake is decoded from registered state only, so ready never
  // depends combinationally on data_valid.
  assign data_ready = (state == S_IDLE);
  assign busy       = ~data_ready;

  // State register plus datapath registers; synchronous active-low reset
  // aborts any frame in flight and returns the line to mark.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, so the order of these statements is irrelevant.
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx_out     <= 1'b1;
`ifdef ODD_PARITY_SER_TWO_STOP_EN
      stop2      <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_cnt_next;
      bit_idx    <= bit_idx_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      tx_out     <= tx_next;
`ifdef ODD_PARITY_SER_TWO_STOP_EN
      stop2      <= stop2_next;
`endif
    end
  end

  // Next-state and next-output logic. tx_next is the value the line shows
  // in the cycle after this edge, which is why the start bit appears the
  // cycle after the accept edge.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_next    = state;
    baud_cnt_next = bit_end ? '0 : baud_cnt + CNT_ONE;
    bit_idx_next  = bit_idx;
    shift_next    = shift_reg;
    parity_next   = parity_bit;
    tx_next       = tx_out;
`ifdef ODD_PARITY_SER_TWO_STOP_EN
    stop2_next    = stop2;
`endif

    case (state)
      S_IDLE: begin
        baud_cnt_next = '0;
        tx_next       = 1'b1;
        if (data_valid) begin
          state_next   = S_START;
          shift_next   = data_in;
          parity_next  = ~^data_in;
          bit_idx_next = '0;
          tx_next      = 1'b0;
`ifdef ODD_PARITY_SER_TWO_STOP_EN
          stop2_next   = 1'b0;
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          tx_next    = shift_reg[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            state_next = S_PARITY;
            tx_next    = parity_bit;
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = shift_reg[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
        end
      end

      S_STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
`ifdef ODD_PARITY_SER_TWO_STOP_EN
          if (!stop2) begin
            stop2_next = 1'b1;
          end else begin
            state_next = S_IDLE;
          end
`else
          state_next = S_IDLE;
`endif
        end
      end

      default: begin
        state_next    = S_IDLE;
        baud_cnt_next = '0;
        tx_next       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_odd_parity_serializer.sv
// Self-checking bench for odd_parity_serializer. Three instances run with
// CLKS_PER_BIT = 4, 1 and 2. Expected frames are built from the byte and a
// hand-computed parity bit held in the vector table.
module tb_odd_parity_serializer;

`ifdef ODD_PARITY_SER_TWO_STOP_EN
  localparam int NBITS = 12;
`else
  localparam int NBITS = 11;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] data4, data1, data2;
  logic       valid4, valid1, valid2;
  logic       ready4, ready1, ready2;
  logic       tx4, tx1, tx2;
  logic       busy4, busy1, busy2;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  odd_parity_serializer #(.CLKS_PER_BIT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .data_in(data4), .data_valid(valid4),
    .data_ready(ready4), .tx_out(tx4), .busy(busy4));

  odd_parity_serializer #(.CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(data1), .data_valid(valid1),
    .data_ready(ready1), .tx_out(tx1), .busy(busy1));

  odd_parity_serializer #(.CLKS_PER_BIT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(data2), .data_valid(valid2),
    .data_ready(ready2), .tx_out(tx2), .busy(busy2));

  typedef struct {
    int         sel;   // instance: 4, 1 or 2 (equals its CLKS_PER_BIT)
    logic [7:0] data;
    logic       par;   // hand-computed odd parity
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      1: return tx1;
      2: return tx2;
      default: return tx4;
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    case (sel)
      1: return ready1;
      2: return ready2;
      default: return ready4;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1: return busy1;
      2: return busy2;
      default: return busy4;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] d);
    case (sel)
      1: begin valid1 = v; data1 = d; end
      2: begin valid2 = v; data2 = d; end
      default: begin valid4 = v; data4 = d; end
    endcase
  endtask

  task automatic check_idle(input int sel, input string tag);
    check($sformatf("%s u%0d tx", tag, sel), get_tx(sel), 1);
    check($sformatf("%s u%0d ready", tag, sel), get_ready(sel), 1);
    check($sformatf("%s u%0d busy", tag, sel), get_busy(sel), 0);
  endtask

  // Called right after the accept edge. Checks every cycle of the frame,
  // then the single idle cycle that follows. At the first frame cycle the
  // inputs are changed to (nv, nd) to show they do not disturb the frame.
  task automatic frame_check(input int sel, input logic [7:0] d, input logic par,
                             input logic nv, input logic [7:0] nd);
    logic [11:0] fb;
    fb      = 12'hC00;  // bits 10 and 11: stop bits
    fb[0]   = 1'b0;
    fb[8:1] = d;
    fb[9]   = par;
    for (int i = 0; i < NBITS * sel; i++) begin
      @(negedge clk);
      if (i == 0) set_in(sel, nv, nd);
      check($sformatf("u%0d byte %02h cycle %0d tx", sel, d, i), get_tx(sel), fb[i / sel]);
      check($sformatf("u%0d byte %02h cycle %0d ready", sel, d, i), get_ready(sel), 0);
      check($sformatf("u%0d byte %02h cycle %0d busy", sel, d, i), get_busy(sel), 1);
    end
    @(negedge clk);
    check_idle(sel, $sformatf("after byte %02h", d));
  endtask

  task automatic send_one(input int sel, input logic [7:0] d, input logic par);
    @(negedge clk);
    check($sformatf("u%0d ready before %02h", sel, d), get_ready(sel), 1);
    set_in(sel, 1'b1, d);
    @(posedge clk);
    frame_check(sel, d, par, 1'b0, ~d);
  endtask

  vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 8'h01, 1'b0};
    vecs[1] = '{4, 8'h00, 1'b1};
    vecs[2] = '{4, 8'hFF, 1'b1};
    vecs[3] = '{4, 8'hA5, 1'b1};
    vecs[4] = '{4, 8'h07, 1'b0};
    vecs[5] = '{2, 8'h80, 1'b0};
    vecs[6] = '{1, 8'h3C, 1'b1};

    rst_n = 1'b0;
    set_in(4, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle for 50 cycles with no valid: line stays mark, ready high.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_idle(4, $sformatf("idle %0d", i));
    end
    check_idle(1, "idle");
    check_idle(2, "idle");

    // Table-driven single frames.
    for (int v = 0; v < 7; v++) begin
      send_one(vecs[v].sel, vecs[v].data, vecs[v].par);
    end

    // Back-to-back at one clock per bit with data_valid held high: 0xAA is
    // presented during the 0x55 frame and must wait for the idle cycle.
    @(negedge clk);
    set_in(1, 1'b1, 8'h55);
    @(posedge clk);
    frame_check(1, 8'h55, 1'b1, 1'b1, 8'hAA);
    @(posedge clk);
    frame_check(1, 8'hAA, 1'b1, 1'b0, 8'h00);
    repeat (3) begin
      @(negedge clk);
      check_idle(1, "after back-to-back");
    end

    // Reset during DATA bit 3 of 0xF0 (cycles 16..19 of the frame).
    @(negedge clk);
    set_in(4, 1'b1, 8'hF0);
    @(posedge clk);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) set_in(4, 1'b0, 8'h00);
    end
    check("F0 bit3 tx before reset", tx4, 0);
    check("F0 busy before reset", busy4, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(4, "after mid-frame reset");
    repeat (12) begin
      @(negedge clk);
      check_idle(4, "no resume after reset");
    end
    send_one(4, 8'h0F, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/odd_parity_serializer.md
Name: odd_parity_serializer

Overview:
Serial framing stage downstream of the 8-bit odd-parity generator.
- Accepts a byte over a valid/ready handshake and computes its odd parity bit internally (parity = XNOR-reduce of data).
- Shifts out an asynchronous-serial frame: start bit, 8 data bits LSB first, odd parity bit, stop bit.
- Feeds the board-level serial TX pin / link driver.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit period; legal range ≥1; bit counter width = $clog2(CLKS_PER_BIT) (min 1).

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
data_in  input  8  byte to transmit; sampled only on the accept cycle
data_valid  input  1  upstream has a byte on data_in
data_ready  output  1  block can accept a byte this cycle
tx_out  output  1  serial line, idle high (mark)
busy  output  1  frame in progress; equals ~data_ready

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE, tx_out=1, data_ready=1 after the edge, busy=0, all counters and shift register cleared. Reset mid-frame aborts the frame; tx_out returns to 1 on that edge and no partial bits are resumed.
- data_ready = (state==IDLE), decoded from registered state.
  - Accept = data_valid && data_ready at a rising edge.
  - On accept: latch data_in into the shift register and latch parity = ~^data_in.
- States:
  - IDLE: tx_out=1; on accept go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_out=shift_reg[0] for CLKS_PER_BIT cycles per bit, shift right after each bit; 8 bits, bit index 0..7; after bit 7 go to PARITY.
  - PARITY: tx_out=latched parity for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE.
- tx_out is registered.
  - The start bit appears on tx_out in the cycle after the accept edge.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Frame length is 11*CLKS_PER_BIT cycles (12*CLKS_PER_BIT with the optional feature).
- Baud counter: counts 0..CLKS_PER_BIT-1; a bit ends when the counter reaches CLKS_PER_BIT-1, then the counter wraps to 0.
  - CLKS_PER_BIT=1 gives one bit per clock.
- Back-to-back: with data_valid held high, the next accept occurs on the first IDLE cycle. This gives exactly one clk of idle mark between frames.
- data_valid while busy: ignored, no effect; upstream must hold data until data_ready.
- data_in changes after accept: no effect on the frame in flight.
- Parity: odd, so data plus parity has an odd number of 1s. 0x00→1, 0xFF→1, 0x01→0.

Optional Feature:
Macro ODD_PARITY_SER_TWO_STOP_EN.
- Defined: STOP lasts 2*CLKS_PER_BIT cycles (two stop bits); frame = 12*CLKS_PER_BIT cycles; back-to-back gap still 1 clk after the second stop bit.
- Undefined: single stop bit as specified above.
- Ports and parameters are identical in both builds.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4, no valid → tx_out=1, data_ready=1, busy=0 for 50 cycles.
- Send 0x01, CLKS_PER_BIT=4 → tx_out sequence per 4-cycle bit: 0,1,0,0,0,0,0,0,0,0(parity),1. data_ready low for 44 cycles after accept, then high.
- Send 0x00, 0xFF, 0xA5, 0x07 → parity bits 1,1,1,0. Sampled bit-centre data matches LSB-first byte.
- data_valid held high with 0x55 then 0xAA, CLKS_PER_BIT=1 → two 11-bit frames separated by exactly one idle-high cycle. Bits: 0,1,0,1,0,1,0,1,0,1(parity),1 | 1 | 0,0,1,0,1,0,1,0,1,1(parity),1. Second byte accepted only on the IDLE cycle.
- rst_n low during DATA bit 3 of 0xF0 → tx_out=1 and data_ready=1 the cycle after the reset edge. A new byte 0x0F sent afterwards frames correctly with parity 1.
- With ODD_PARITY_SER_TWO_STOP_EN, CLKS_PER_BIT=2, send 0x80 → 24-cycle frame: 0, seven 0s, 1, parity 0, stop high for 4 cycles.
